// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared constants for the scanning multiplexer family.
//   MODO_MANUAL    : external select picks the channel
//   MODO_VARREDURA : internal index walks the channels (scan)
//   LW(n)          : index width for n items, never narrower than one bit
// ---------------------------------------------------------------------------
package mux_pkg;

  localparam logic MODO_MANUAL    = 1'b0;
  localparam logic MODO_VARREDURA = 1'b1;

  // Width needed to hold an index 0..n-1, at least 1 bit.
  function automatic int LW(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/mux_comb_n.sv
// ---------------------------------------------------------------------------
// mux_comb_n
// Purely combinational N:1 selector of W-bit words.
//   d_i   [N*W-1:0] : packed channels, channel k at d_i[k*W +: W]
//   sel_i [SW-1:0]  : channel index
//   y_o   [W-1:0]   : selected word (zero when sel_i >= N)
// ---------------------------------------------------------------------------
module mux_comb_n #(
  parameter int N  = 4,
  parameter int W  = 1,
  parameter int SW = 2
) (
  input  logic [N*W-1:0] d_i,
  input  logic [SW-1:0]  sel_i,
  output logic [W-1:0]   y_o
);

  // Decode the select against every channel; an out-of-range index yields zero.
  always_comb begin
    y_o = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_i == SW'(k)) begin
        y_o = d_i[k*W +: W];
      end else begin
      end
    end
  end

endmodule

// File: rtl/mux_varredura_param.sv
// ---------------------------------------------------------------------------
// mux_varredura_param
// N-channel, W-bit registered multiplexer with manual and scan modes.
// In scan mode an internal index holds each channel for DWELL enabled cycles.
// Every output word is tagged with the channel that produced it.
//   clk, rst_n  : clock, asynchronous active-low reset
//   d           : N*W channel data, channel k at d[k*W +: W]
//   sel         : manual channel select
//   modo        : 0 manual, 1 scan
//   en          : advance / sample enable
//   mascara     : per-channel enable (only with MUX_MASCARA_EN defined)
//   y, canal    : registered data and its channel index
//   valid       : y/canal updated this cycle from a legal channel
//   wrap        : one-cycle pulse when the scan index wraps around
// Optional build macro: MUX_MASCARA_EN adds the channel mask port.
// ---------------------------------------------------------------------------
module mux_varredura_param
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DWELL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*W-1:0]     d,
  input  logic [LW(N)-1:0]   sel,
  input  logic               modo,
  input  logic               en,
`ifdef MUX_MASCARA_EN
  input  logic [N-1:0]       mascara,
`endif
  output logic [W-1:0]       y,
  output logic [LW(N)-1:0]   canal,
  output logic               valid,
  output logic               wrap
);

  localparam int SW = LW(N);
  localparam int CW = LW(DWELL);
  localparam logic [SW-1:0] IDX_ULT = SW'(N - 1);
  localparam logic [CW-1:0] CNT_ULT = CW'(DWELL - 1);

  logic [W-1:0]  y_q,     y_d;
  logic [SW-1:0] canal_q, canal_d;
  logic          valid_q, valid_d;
  logic          wrap_q,  wrap_d;
  logic [SW-1:0] idx_q,   idx_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          modo_q,  modo_d;

  logic [N-1:0]  mask_s;
  logic          restart_s;
  logic [SW-1:0] idx_s;
  logic [CW-1:0] cnt_s;
  logic [SW-1:0] nxt_s;
  logic [SW-1:0] sel_mux_s;
  logic [W-1:0]  dado_s;
  logic          sel_ok_s;
  logic          idx_ok_s;

`ifdef MUX_MASCARA_EN
  assign mask_s = mascara;
`else
  assign mask_s = {N{1'b1}};
`endif

  // Next enabled channel after cur, cyclic; returns cur when nothing else is enabled.
  function automatic logic [SW-1:0] prox_canal(input logic [SW-1:0] cur,
                                               input logic [N-1:0]  m);
    logic [SW-1:0] r;
    logic          found;
    r     = cur;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && m[(int'(cur) + i) % N]) begin
        r     = SW'((int'(cur) + i) % N);
        found = 1'b1;
      end else begin
      end
    end
    return r;
  endfunction

  // Entering scan restarts at the first enabled channel with a fresh dwell count.
  assign restart_s = (modo == MODO_VARREDURA) && (modo_q == MODO_MANUAL);
  assign idx_s     = restart_s ? prox_canal(IDX_ULT, mask_s) : idx_q;
  assign cnt_s     = restart_s ? '0 : cnt_q;
  assign nxt_s     = prox_canal(idx_s, mask_s);
  assign sel_mux_s = (modo == MODO_VARREDURA) ? idx_s : sel;

  mux_comb_n #(
    .N  (N),
    .W  (W),
    .SW (SW)
  ) u_sel (
    .d_i   (d),
    .sel_i (sel_mux_s),
    .y_o   (dado_s)
  );

  // Legality of the manual select and of the current scan index (range and mask).
  always_comb begin
    sel_ok_s = 1'b0;
    idx_ok_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) begin
        sel_ok_s = mask_s[k];
      end else begin
      end
      if (idx_s == SW'(k)) begin
        idx_ok_s = mask_s[k];
      end else begin
      end
    end
  end

  // Next-state logic for outputs, scan index, dwell counter and mode history.
  always_comb begin
    y_d     = y_q;
    canal_d = canal_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    modo_d  = modo_q;
    if (en) begin
      modo_d = modo;
      if (modo == MODO_MANUAL) begin
        if (sel_ok_s) begin
          y_d     = dado_s;
          canal_d = sel;
          valid_d = 1'b1;
        end else begin
        end
      end else if (mask_s == '0) begin
        // No channel enabled: hold everything, nothing valid.
        idx_d = idx_s;
        cnt_d = cnt_s;
      end else begin
        // A masked current index still burns its dwell, but emits nothing.
        if (idx_ok_s) begin
          y_d     = dado_s;
          canal_d = idx_s;
          valid_d = 1'b1;
        end else begin
        end
        if (cnt_s == CNT_ULT) begin
          cnt_d  = '0;
          idx_d  = nxt_s;
          wrap_d = (nxt_s <= idx_s);
        end else begin
          cnt_d  = cnt_s + CW'(1);
          idx_d  = idx_s;
        end
      end
    end else begin
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      canal_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      modo_q  <= MODO_MANUAL;
    end else begin
      y_q     <= y_d;
      canal_q <= canal_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      modo_q  <= modo_d;
    end
  end

  assign y     = y_q;
  assign canal = canal_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_varredura_param.sv
// ---------------------------------------------------------------------------
// tb_mux_varredura_param
// Directed bench for the scanning multiplexer (N=4, W=8, DWELL=2).
// Each step drives inputs, queues the expected output word and compares it
// one cycle later.
// ---------------------------------------------------------------------------
module tb_mux_varredura_param;

  logic        clk;
  logic        rst_n;
  logic [31:0] d;
  logic [1:0]  sel;
  logic        modo;
  logic        en;
  logic [7:0]  y;
  logic [1:0]  canal;
  logic        valid;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] y;
    logic [1:0] c;
    logic       v;
    logic       w;
    string      tag;
  } exp_t;

  exp_t sb[$];

  mux_varredura_param #(
    .N     (4),
    .W     (8),
    .DWELL (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .sel   (sel),
    .modo  (modo),
    .en    (en),
    .y     (y),
    .canal (canal),
    .valid (valid),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ey, input logic [1:0] ec,
                         input logic ev, input logic ew);
    chk({tag, ".y"},     y,             ey);
    chk({tag, ".canal"}, {6'd0, canal}, {6'd0, ec});
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, ev});
    chk({tag, ".wrap"},  {7'd0, wrap},  {7'd0, ew});
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic step(input logic en_v, input logic modo_v, input logic [1:0] sel_v,
                      input logic [7:0] ey, input logic [1:0] ec,
                      input logic ev, input logic ew, input string tag);
    exp_t e;
    en   = en_v;
    modo = modo_v;
    sel  = sel_v;
    sb.push_back('{y: ey, c: ec, v: ev, w: ew, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_all(e.tag, e.y, e.c, e.v, e.w);
  endtask

  logic [7:0] sweep_y [9];
  logic [1:0] sweep_c [9];
  logic       sweep_w [9];

  initial begin
    sweep_y = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h11};
    sweep_c = '{2'd0,  2'd0,  2'd1,  2'd1,  2'd2,  2'd2,  2'd3,  2'd3,  2'd0};
    sweep_w = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};

    rst_n = 1'b1;
    en    = 1'b0;
    modo  = 1'b0;
    sel   = 2'd0;
    d     = 32'h4433_2211;
    #2 rst_n = 1'b0;
    #1 chk_all("reset", 8'h00, 2'd0, 1'b0, 1'b0);
    #10 rst_n = 1'b1;

    // Manual selection and hold with enable low.
    step(1'b1, 1'b0, 2'd2, 8'h33, 2'd2, 1'b1, 1'b0, "man_sel2");
    step(1'b0, 1'b0, 2'd2, 8'h33, 2'd2, 1'b0, 1'b0, "man_hold");

    // Full sweep plus the first word of the next one.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 2'd0, sweep_y[i], sweep_c[i], 1'b1, sweep_w[i],
           $sformatf("sweep%0d", i));
    end

    // Data sampled every cycle: new ch0 value shows on the second dwell cycle.
    d[7:0] = 8'hA5;
    step(1'b1, 1'b1, 2'd0, 8'hA5, 2'd0, 1'b1, 1'b0, "dwell_data");
    d[7:0] = 8'h11;

    // Freeze during ch1 dwell, then finish ch1 and move to ch2.
    step(1'b1, 1'b1, 2'd0, 8'h22, 2'd1, 1'b1, 1'b0, "ch1_first");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 2'd0, 8'h22, 2'd1, 1'b0, 1'b0, $sformatf("freeze%0d", i));
    end
    step(1'b1, 1'b1, 2'd0, 8'h22, 2'd1, 1'b1, 1'b0, "ch1_resume");
    step(1'b1, 1'b1, 2'd0, 8'h33, 2'd2, 1'b1, 1'b0, "ch2_first");

    // Manual detour, then back to scan restarting at ch0.
    step(1'b1, 1'b0, 2'd3, 8'h44, 2'd3, 1'b1, 1'b0, "man_sel3");
    step(1'b1, 1'b1, 2'd0, 8'h11, 2'd0, 1'b1, 1'b0, "rescan0");
    step(1'b1, 1'b1, 2'd0, 8'h11, 2'd0, 1'b1, 1'b0, "rescan1");
    step(1'b1, 1'b1, 2'd0, 8'h22, 2'd1, 1'b1, 1'b0, "rescan2");

    // Asynchronous reset mid-scan, checked before any further clock edge.
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 8'h00, 2'd0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step(1'b1, 1'b1, 2'd0, 8'h11, 2'd0, 1'b1, 1'b0, "post_rst0");
    step(1'b1, 1'b1, 2'd0, 8'h11, 2'd0, 1'b1, 1'b0, "post_rst1");
    step(1'b1, 1'b1, 2'd0, 8'h22, 2'd1, 1'b1, 1'b0, "post_rst2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
